// File: rtl/arm_cond_pkg.sv
// Shared types for the conditional-execution stage: ARM condition codes and
// NZCV flag bit positions.
package arm_cond_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against the held NZCV flags.
// The reserved NV encoding never passes.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_ex
);

    logic n_f, z_f, c_f, v_f;
    logic ge_f;

    assign n_f  = flags[FLAG_N];
    assign z_f  = flags[FLAG_Z];
    assign c_f  = flags[FLAG_C];
    assign v_f  = flags[FLAG_V];
    assign ge_f = (n_f == v_f);

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_e'(cond))
            EQ: cond_ex = z_f;
            NE: cond_ex = ~z_f;
            CS: cond_ex = c_f;
            CC: cond_ex = ~c_f;
            MI: cond_ex = n_f;
            PL: cond_ex = ~n_f;
            VS: cond_ex = v_f;
            VC: cond_ex = ~v_f;
            HI: cond_ex = c_f & ~z_f;
            LS: cond_ex = ~c_f | z_f;
            GE: cond_ex = ge_f;
            LT: cond_ex = ~ge_f;
            GT: cond_ex = ~z_f & ge_f;
            LE: cond_ex = z_f | ~ge_f;
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// Conditional-execution stage: NZCV flag register, condition check, write-strobe
// gating and saturating executed/squashed instruction counters.
module cond_logic_unit
    import arm_cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               NoWrite,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [FLAGS_W-1:0] Flags,
    output logic [CNT_W-1:0]   exec_cnt,
    output logic [CNT_W-1:0]   skip_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]   exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic               cond_ex;
    logic               issue;

    // Condition uses registered flags only; no same-cycle ALU flag bypass.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign issue = en & cond_ex;

    always_comb begin
        flags_d    = flags_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;

        if (issue) begin
            if (FlagW[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end

        // Exactly one counter advances per valid instruction, saturating at max.
        if (en) begin
            if (cond_ex) begin
                if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end else begin
                if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            flags_q    <= flags_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = issue & PCS;
    assign RegWrite = issue & RegW & ~NoWrite;
    assign MemWrite = issue & MemW;
    assign Flags    = flags_q;
    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Directed-vector bench for cond_logic_unit, built with 4-bit counters so that
// saturation is reachable quickly.
module tb_cond_logic_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] exec_cnt, skip_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    cond_logic_unit #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .exec_cnt (exec_cnt),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction's inputs just after a rising edge.
    task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic rw,
                         input logic mw, input logic nw);
        en = e; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic golden(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: golden = z;
            4'h1: golden = !z;
            4'h2: golden = cf;
            4'h3: golden = !cf;
            4'h4: golden = n;
            4'h5: golden = !n;
            4'h6: golden = v;
            4'h7: golden = !v;
            4'h8: golden = cf && !z;
            4'h9: golden = !cf || z;
            4'hA: golden = (n == v);
            4'hB: golden = (n != v);
            4'hC: golden = !z && (n == v);
            4'hD: golden = z || (n != v);
            4'hE: golden = 1'b1;
            default: golden = 1'b0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_flags", 32'(Flags), 32'h0);
        check("rst_exec", 32'(exec_cnt), 32'd0);
        check("rst_skip", 32'(skip_cnt), 32'd0);
        reset = 1'b0;

        // AL with register write
        drive(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
        check("al_regwrite", 32'(RegWrite), 32'd1);
        check("al_condex", 32'(CondEx), 32'd1);
        tick();
        check("al_exec", 32'(exec_cnt), 32'd1);
        check("al_flags", 32'(Flags), 32'h0);

        // CMP: sets Z, suppresses register write
        drive(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
        check("cmp_regwrite", 32'(RegWrite), 32'd0);
        check("cmp_flags_same_cycle", 32'(Flags), 32'h0);
        tick();
        check("cmp_flags", 32'(Flags), 32'h4);
        drive(1, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
        check("eq_memwrite", 32'(MemWrite), 32'd1);
        tick();
        check("eq_exec", 32'(exec_cnt), 32'd3);
        drive(1, 4'h1, 4'h0, 2'b00, 0, 0, 1, 0);
        check("ne_memwrite", 32'(MemWrite), 32'd0);
        check("ne_condex", 32'(CondEx), 32'd0);
        tick();
        check("ne_skip", 32'(skip_cnt), 32'd1);
        check("ne_exec_hold", 32'(exec_cnt), 32'd3);

        // Independent NZ / CV group writes
        drive(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        tick();
        check("set_all_flags", 32'(Flags), 32'hF);
        drive(1, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0);
        tick();
        check("nz_only", 32'(Flags), 32'h3);
        drive(1, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0);
        tick();
        check("cv_only", 32'(Flags), 32'h0);
        check("partial_exec", 32'(exec_cnt), 32'd6);

        // Squashed flag setter with PCS
        drive(1, 4'h0, 4'hF, 2'b11, 1, 0, 0, 0);
        check("squash_pcsrc", 32'(PCSrc), 32'd0);
        tick();
        check("squash_flags", 32'(Flags), 32'h0);
        check("squash_skip", 32'(skip_cnt), 32'd2);

        // Stall: everything gated, state held
        drive(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
        check("stall_pcsrc", 32'(PCSrc), 32'd0);
        check("stall_regwrite", 32'(RegWrite), 32'd0);
        check("stall_memwrite", 32'(MemWrite), 32'd0);
        tick();
        check("stall_flags", 32'(Flags), 32'h0);
        check("stall_exec", 32'(exec_cnt), 32'd6);
        check("stall_skip", 32'(skip_cnt), 32'd2);

        // Executed PC write, then reset while stalled
        drive(1, 4'hE, 4'b1010, 2'b11, 1, 0, 0, 0);
        check("al_pcsrc", 32'(PCSrc), 32'd1);
        tick();
        check("pre_rst_flags", 32'(Flags), 32'hA);
        reset = 1'b1;
        drive(0, 4'hE, 4'h5, 2'b11, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        check("stall_rst_flags", 32'(Flags), 32'h0);
        check("stall_rst_exec", 32'(exec_cnt), 32'd0);
        check("stall_rst_skip", 32'(skip_cnt), 32'd0);

        // Reset wins over an enabled flag write
        drive(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_over_en_flags", 32'(Flags), 32'h0);
        check("rst_over_en_exec", 32'(exec_cnt), 32'd0);

        // All conditions against all flag values
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
            tick();
            check("exh_flags", 32'(Flags), 32'(f));
            for (int c = 0; c < 16; c++) begin
                drive(0, 4'(c), 4'h0, 2'b00, 0, 0, 0, 0);
                check($sformatf("exh_c%0h_f%0h", c, f), 32'(CondEx), 32'(golden(4'(c), 4'(f))));
            end
        end

        // Counter saturation
        reset = 1'b1;
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
            tick();
        end
        check("exec_at_max", 32'(exec_cnt), 32'd15);
        drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        check("exec_saturated", 32'(exec_cnt), 32'd15);
        check("sat_skip_zero", 32'(skip_cnt), 32'd0);
        drive(1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        check("nv_condex", 32'(CondEx), 32'd0);
        tick();
        check("nv_skip", 32'(skip_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
